// File: rtl/pkt_seq_checker.sv
// Packet header/sequence checker: accepts beats with a valid header and in-order sequence number and word-reverses them.
// Optional saturating error counter compiled in by PKT_SEQ_CHECKER_ERR_CNT_EN.
module pkt_seq_checker #(
    parameter int                   BUS_SIZE  = 16,
    parameter int                   WORD_SIZE = 4,
    parameter logic [WORD_SIZE-1:0] HDR_VAL   = {WORD_SIZE{1'b1}},
    parameter int                   ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [BUS_SIZE-1:0]  bus_data_in,
    output logic                 out_valid,
    output logic [BUS_SIZE-1:0]  bus_data_out,
    output logic [2:0]           state,
    output logic                 error,
    output logic [WORD_SIZE-1:0] seq_exp,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int WORD_NUM = BUS_SIZE / WORD_SIZE;
    localparam logic [WORD_SIZE-1:0] SEQ_ONE = WORD_SIZE'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FIRST_PKT = 3'd1,
        REG_PKT   = 3'd2,
        F_ERROR   = 3'd3,
        SEQ_ERROR = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic [BUS_SIZE-1:0]   data_out_q, data_out_d;
    logic                  error_q, error_d;
    logic [WORD_SIZE-1:0]  seq_exp_q, seq_exp_d;
    logic                  accept, reject;
    logic                  hdr_ok, seq_ok;
    logic [WORD_SIZE-1:0]  seq_in;
    logic [BUS_SIZE-1:0]   data_rev;

    assign hdr_ok = (bus_data_in[BUS_SIZE-1 -: WORD_SIZE] == HDR_VAL);
    assign seq_in = bus_data_in[WORD_SIZE-1:0];
    assign seq_ok = (seq_in == seq_exp_q);

    always_comb begin
        data_rev = '0;
        for (int i = 0; i < WORD_NUM; i++) begin
            data_rev[(WORD_NUM-1-i)*WORD_SIZE +: WORD_SIZE] =
                bus_data_in[i*WORD_SIZE +: WORD_SIZE];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Header failure outranks sequence failure in REG_PKT.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        case (state_q)
            IDLE: state_d = FIRST_PKT;
            FIRST_PKT, F_ERROR, SEQ_ERROR: begin
                if (in_valid) begin
                    if (hdr_ok) begin
                        state_d = REG_PKT;
                        accept  = 1'b1;
                    end else begin
                        state_d = F_ERROR;
                        reject  = 1'b1;
                    end
                end
            end
            REG_PKT: begin
                if (in_valid) begin
                    if (!hdr_ok) begin
                        state_d = F_ERROR;
                        reject  = 1'b1;
                    end else if (!seq_ok) begin
                        state_d = SEQ_ERROR;
                        reject  = 1'b1;
                    end else begin
                        accept  = 1'b1;
                    end
                end
            end
            default: state_d = FIRST_PKT;
        endcase
    end

    always_comb begin
        out_valid_d = accept;
        data_out_d  = accept ? data_rev : data_out_q;
        seq_exp_d   = accept ? seq_in + SEQ_ONE : seq_exp_q;
        error_d     = (state_d == F_ERROR) || (state_d == SEQ_ERROR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            seq_exp_q   <= '0;
            error_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            seq_exp_q   <= seq_exp_d;
            error_q     <= error_d;
        end
    end

`ifdef PKT_SEQ_CHECKER_ERR_CNT_EN
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (reject && (err_cnt_q != {ERR_CNT_W{1'b1}}))
            err_cnt_d = err_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!reset) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_reject;
    assign unused_reject = reject;
    assign err_cnt = '0;
`endif

    assign out_valid    = out_valid_q;
    assign bus_data_out = data_out_q;
    assign state        = state_q;
    assign error        = error_q;
    assign seq_exp      = seq_exp_q;

endmodule

// File: tb/tb_pkt_seq_checker.sv
// Directed vector bench for pkt_seq_checker; second instance exercises
// error-counter saturation with a 2-bit counter.
module tb_pkt_seq_checker;

    logic        clk = 1'b0;
    logic        reset, in_valid;
    logic [15:0] bus_data_in, bus_data_out;
    logic        out_valid, error;
    logic [2:0]  state;
    logic [3:0]  seq_exp;
    logic [7:0]  err_cnt;

    logic        reset2, in_valid2;
    logic [15:0] din2, dout2;
    logic        ov2, err2;
    logic [2:0]  st2;
    logic [3:0]  sq2;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pkt_seq_checker dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .bus_data_in(bus_data_in), .out_valid(out_valid),
        .bus_data_out(bus_data_out), .state(state), .error(error),
        .seq_exp(seq_exp), .err_cnt(err_cnt)
    );

    pkt_seq_checker #(.ERR_CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset2), .in_valid(in_valid2),
        .bus_data_in(din2), .out_valid(ov2),
        .bus_data_out(dout2), .state(st2), .error(err2),
        .seq_exp(sq2), .err_cnt(cnt2)
    );

`ifdef PKT_SEQ_CHECKER_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic        rst_n;
        logic        vld;
        logic [15:0] din;
        logic [2:0]  st;
        logic        ov;
        logic [15:0] dout;
        logic        er;
        logic [3:0]  sq;
        logic        inc;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h",
                     nm, idx, act, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_cnt;
        logic [1:0] exp_sat;
        //               rst vld din      st  ov dout     er sq  inc
        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 16'hF000, 3'd0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 16'hF000, 3'd1, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 16'hF000, 3'd2, 1'b1, 16'h000F, 1'b0, 4'h1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 16'hF001, 3'd2, 1'b1, 16'h100F, 1'b0, 4'h2, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 16'hF002, 3'd2, 1'b1, 16'h200F, 1'b0, 4'h3, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 16'hF003, 3'd2, 1'b0, 16'h200F, 1'b0, 4'h3, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 16'hF005, 3'd4, 1'b0, 16'h200F, 1'b1, 4'h3, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 16'hF009, 3'd2, 1'b1, 16'h900F, 1'b0, 4'hA, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 16'hE007, 3'd3, 1'b0, 16'h900F, 1'b1, 4'hA, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 16'hE00A, 3'd3, 1'b0, 16'h900F, 1'b1, 4'hA, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 16'hF00E, 3'd2, 1'b1, 16'hE00F, 1'b0, 4'hF, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 16'hF00F, 3'd2, 1'b1, 16'hF00F, 1'b0, 4'h0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 16'hF000, 3'd2, 1'b1, 16'h000F, 1'b0, 4'h1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 16'hF001, 3'd2, 1'b0, 16'h000F, 1'b0, 4'h1, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 16'hF001, 3'd2, 1'b1, 16'h100F, 1'b0, 4'h2, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 16'hF002, 3'd0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 16'hF000, 3'd1, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 16'hA123, 3'd3, 1'b0, 16'h0000, 1'b1, 4'h0, 1'b1};
        vecs[19] = '{1'b1, 1'b1, 16'hF123, 3'd2, 1'b1, 16'h321F, 1'b0, 4'h4, 1'b0};
        vecs[20] = '{1'b1, 1'b1, 16'hF125, 3'd4, 1'b0, 16'h321F, 1'b1, 4'h4, 1'b1};
        vecs[21] = '{1'b1, 1'b1, 16'h0124, 3'd3, 1'b0, 16'h321F, 1'b1, 4'h4, 1'b1};

        reset = 1'b0; in_valid = 1'b0; bus_data_in = '0;
        reset2 = 1'b0; in_valid2 = 1'b0; din2 = '0;
        exp_cnt = '0;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            reset       = vecs[i].rst_n;
            in_valid    = vecs[i].vld;
            bus_data_in = vecs[i].din;
            @(posedge clk);
            #1;
            if (!vecs[i].rst_n) exp_cnt = '0;
            else if (CNT_EN && vecs[i].inc && exp_cnt != 8'hFF)
                exp_cnt = exp_cnt + 8'd1;
            chk("state", i, 32'(state), 32'(vecs[i].st));
            chk("out_valid", i, 32'(out_valid), 32'(vecs[i].ov));
            chk("bus_data_out", i, 32'(bus_data_out), 32'(vecs[i].dout));
            chk("error", i, 32'(error), 32'(vecs[i].er));
            chk("seq_exp", i, 32'(seq_exp), 32'(vecs[i].sq));
            chk("err_cnt", i, 32'(err_cnt), 32'(exp_cnt));
        end

        @(negedge clk);
        in_valid = 1'b0;

        // Saturation: five bad-header beats into a 2-bit counter.
        @(negedge clk);
        reset2 = 1'b0;
        @(negedge clk);
        reset2 = 1'b1; in_valid2 = 1'b1; din2 = 16'h0000;
        @(posedge clk);
        #1;
        chk("sat_state_first", 0, 32'(st2), 32'd1);
        exp_sat = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            din2 = 16'h1230 | 16'(k);
            @(posedge clk);
            #1;
            if (CNT_EN && exp_sat != 2'd3) exp_sat = exp_sat + 2'd1;
            chk("sat_err_cnt", k, 32'(cnt2), 32'(exp_sat));
            chk("sat_error", k, 32'(err2), 32'd1);
        end
        chk("sat_final", 5, 32'(cnt2), CNT_EN ? 32'd3 : 32'd0);

        @(negedge clk);
        reset2 = 1'b0; in_valid2 = 1'b1; din2 = 16'hF000;
        @(posedge clk);
        #1;
        chk("sat_reset_cnt", 6, 32'(cnt2), 32'd0);
        chk("sat_reset_state", 6, 32'(st2), 32'd0);
        chk("sat_reset_out", 6, 32'(dout2), 32'd0);
        chk("sat_reset_ov", 6, 32'(ov2), 32'd0);
        chk("sat_reset_seq", 6, 32'(sq2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_seq_checker.md
PKT_SEQ_CHECKER -- requirements
Module: pkt_seq_checker

Interface
REQ-001 Parameter BUS_SIZE, default 16, SHALL set the input/output bus width in bits.
REQ-002 Parameter WORD_SIZE, default 4, SHALL set the word width; BUS_SIZE SHALL be an integer multiple of WORD_SIZE, with WORD_NUM = BUS_SIZE/WORD_SIZE >= 2.
REQ-003 Parameter HDR_VAL, default all-ones of WORD_SIZE bits, SHALL set the required header word value.
REQ-004 Parameter ERR_CNT_W, default 8, SHALL set the error-counter width.
REQ-005 Port clk, input, 1 bit, SHALL be the clock; reset is synchronous, active-low, named reset.
REQ-006 Port reset, input, 1 bit, SHALL be the synchronous active-low reset.
REQ-007 Port in_valid, input, 1 bit, SHALL qualify bus_data_in as a packet beat.
REQ-008 Port bus_data_in, input, BUS_SIZE bits, SHALL carry the packet: header in the top word, sequence number in the bottom word.
REQ-009 Port out_valid, output, 1 bit, SHALL flag an accepted packet on bus_data_out.
REQ-010 Port bus_data_out, output, BUS_SIZE bits, SHALL carry the word-reversed accepted packet.
REQ-011 Port state, output, 3 bits, SHALL expose the current FSM state.
REQ-012 Port error, output, 1 bit, SHALL be high while the FSM is in an error state.
REQ-013 Port seq_exp, output, WORD_SIZE bits, SHALL expose the expected next sequence number.
REQ-014 Port err_cnt, output, ERR_CNT_W bits, SHALL expose the error count (see Configuration).

Function
REQ-015 States SHALL be IDLE=0, FIRST_PKT=1, REG_PKT=2, F_ERROR=3, SEQ_ERROR=4; all outputs SHALL be registered.
REQ-016 The FSM SHALL leave IDLE for FIRST_PKT one cycle after reset deasserts, irrespective of in_valid; a beat in the IDLE cycle is ignored.
REQ-017 Cycles with in_valid=0 SHALL hold state, seq_exp and bus_data_out, and drive out_valid=0.
REQ-018 In FIRST_PKT, F_ERROR or SEQ_ERROR, a valid beat with header==HDR_VAL SHALL be accepted regardless of sequence, set seq_exp = seq+1 and go to REG_PKT.
REQ-019 In FIRST_PKT, F_ERROR or SEQ_ERROR, a valid beat with header!=HDR_VAL SHALL go to F_ERROR.
REQ-020 In REG_PKT, a valid beat with header!=HDR_VAL SHALL go to F_ERROR; header check has priority over sequence check.
REQ-021 In REG_PKT, a valid beat with correct header and seq!=seq_exp SHALL go to SEQ_ERROR, seq_exp unchanged.
REQ-022 In REG_PKT, a valid beat with correct header and seq==seq_exp SHALL be accepted, remain in REG_PKT, seq_exp incremented.
REQ-023 seq_exp SHALL wrap modulo 2^WORD_SIZE (e.g. 0xF -> 0x0 for WORD_SIZE=4) without error.
REQ-024 Each accepted beat SHALL appear next cycle on bus_data_out with out_valid=1, word i of input at word WORD_NUM-1-i of output; rejected beats SHALL drive out_valid=0 and not update bus_data_out.
REQ-025 error SHALL be 1 exactly while state is F_ERROR or SEQ_ERROR; consecutive bad beats keep error high.
REQ-026 Illegal state encodings (5-7) SHALL return to FIRST_PKT on the next cycle with error=0.

Reset
REQ-027 While reset=0 at a clock edge: state=IDLE, error=0, out_valid=0, bus_data_out=0, seq_exp=0, err_cnt=0.
REQ-028 Reset asserted mid-stream SHALL abort in one cycle, discarding the beat present in that cycle.

Configuration
REQ-029 Macro PKT_SEQ_CHECKER_ERR_CNT_EN SHALL compile in the error counter.
REQ-030 With the macro defined, err_cnt SHALL increment by one on every rejected valid beat and saturate at 2^ERR_CNT_W-1.
REQ-031 Without the macro, err_cnt SHALL be constant 0 and no counter logic SHALL exist; all other behaviour identical.

Verification
REQ-032 Reset, then beats 0xF000,0xF001,0xF002 -> out_valid each following cycle, bus_data_out 0x000F,0x100F,0x200F, state 2, error 0.
REQ-033 In REG_PKT expecting 3, beat 0xF005 -> state 4, error 1, out_valid 0; next 0xF009 -> accepted, seq_exp 0xA, error 0.
REQ-034 In REG_PKT, beat 0xE007 (header and seq wrong) -> state 3 (F_ERROR), err_cnt +1 with macro, 0 without.
REQ-035 Sequence 0xF00E,0xF00F,0xF000 -> all accepted, seq_exp wraps to 0x1, error stays 0.
REQ-036 Beat stream with in_valid toggling, reset=0 asserted mid-stream -> next cycle all outputs at reset values, state 0.
REQ-037 With macro and ERR_CNT_W=2, five bad-header beats -> err_cnt saturates at 3.
